// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply and divide datapath blocks.
// Both blocks use the same operand width default and FSM state encodings.
package mul_div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add step: conditionally add M into A, then shift {A,Q} right by one.
// Purely combinational, so it can be chained for an unrolled or pipelined variant.
module mul_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum_s;

    // Conditional add on the multiplier LSB, carry kept in the top bit, then shift right.
    always_comb begin
        if (q[0]) begin
            sum_s = a + {1'b0, m};
        end else begin
            sum_s = a;
        end
        a_next = {1'b0, sum_s[WIDTH:1]};
        q_next = {sum_s[0], q[WIDTH-1:1]};
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential multiply-accumulate: product = multiplicand*multiplier + addend.
// Also rebuilds the dividend from divider outputs (quotient, divisor, remainder).
module shift_add_multiplier
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 St,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e               state_r;
    logic [WIDTH:0]       a_r;
    logic [WIDTH-1:0]     q_r;
    logic [WIDTH-1:0]     m_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   product_r;
    logic [WIDTH:0]       a_next_s;
    logic [WIDTH-1:0]     q_next_s;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_r),
        .q      (q_r),
        .m      (m_r),
        .a_next (a_next_s),
        .q_next (q_next_s)
    );

    // Control FSM plus datapath registers; addend preloaded in A lands at weight 2^0 after WIDTH shifts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= S_IDLE;
            a_r       <= '0;
            q_r       <= '0;
            m_r       <= '0;
            cnt_r     <= '0;
            product_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (St) begin
                        m_r     <= multiplicand;
                        q_r     <= multiplier;
                        a_r     <= {1'b0, addend};
                        cnt_r   <= '0;
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_r   <= a_next_s;
                    q_r   <= q_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_STEP) begin
                        product_r <= {a_next_s[WIDTH-1:0], q_next_s};
                        state_r   <= S_DONE;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign product = product_r;
    assign Busy    = (state_r != S_IDLE);
    assign Done    = (state_r == S_DONE);

endmodule
